instr_fetch_seq: RTL

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

---
 rtl/instr_fetch_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: byte fetch with CB-prefix merge, issue handshake and jumps.
// Optional interrupt pseudo-opcode injection is enabled by defining INTR_INJECT_EN.
module instr_fetch_seq #(
  parameter logic [15:0] RST_PC     = 16'h0000,
  parameter logic [8:0]  IRQ_OPCODE = 9'h1D4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [8:0]  opcode,
  output logic        opcode_valid,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] pc
`ifdef INTR_INJECT_EN
  ,
  input  logic        irq_req,
  output logic        irq_ack
`endif
);

  // state    | meaning
  // IDLE     | one-cycle settle after reset
  // FETCH    | reading an opcode byte at pc
  // FETCH_CB | reading the byte that follows a CB prefix
  // ISSUE    | opcode held valid until exec_done
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    FETCH_CB = 2'd2,
    ISSUE    = 2'd3
  } state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  // Opcodes at or above 475 collide with the microcode table tail.
  if (IRQ_OPCODE >= 9'd475) begin : g_irq_opcode_check
    $error("IRQ_OPCODE must be below 475");
  end

  state_t state, state_nxt;
  logic   take_irq;

`ifdef INTR_INJECT_EN
  logic in_irq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_irq  = 1'b0;
    case (state)
      IDLE:     state_nxt = FETCH;
      FETCH:    if (mem_ack) state_nxt = (mem_rdata == CB_PREFIX) ? FETCH_CB : ISSUE;
      FETCH_CB: if (mem_ack) state_nxt = ISSUE;
      ISSUE: begin
        if (exec_done) begin
`ifdef INTR_INJECT_EN
          // An injected opcode always returns to FETCH, so interrupts never chain.
          if (irq_req && !in_irq) take_irq = 1'b1;
          else                    state_nxt = FETCH;
`else
          state_nxt = FETCH;
`endif
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RST_PC;
      opcode <= 9'h000;
`ifdef INTR_INJECT_EN
      irq_ack <= 1'b0;
      in_irq  <= 1'b0;
`endif
    end else begin
`ifdef INTR_INJECT_EN
      irq_ack <= 1'b0;
`endif
      case (state)
        FETCH: begin
          if (mem_ack) begin
            pc <= pc + 16'd1;
            if (mem_rdata != CB_PREFIX) opcode <= {1'b0, mem_rdata};
          end
        end
        FETCH_CB: begin
          if (mem_ack) begin
            pc     <= pc + 16'd1;
            opcode <= {1'b1, mem_rdata};
          end
        end
        ISSUE: begin
          if (pc_load) pc <= pc_load_val;
`ifdef INTR_INJECT_EN
          if (take_irq) begin
            opcode  <= IRQ_OPCODE;
            irq_ack <= 1'b1;
            in_irq  <= 1'b1;
          end else if (exec_done) begin
            in_irq <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef INTR_INJECT_EN
  logic unused_take_irq;
  assign unused_take_irq = take_irq;
`endif

  assign mem_req      = (state == FETCH) || (state == FETCH_CB);
  assign mem_addr     = pc;
  assign opcode_valid = (state == ISSUE);

endmodule
